shugart_step_rx: RTL and testbench

Host-side receiver for the Shugart STEP/DIR head-positioning signals, sitting directly upstream of the floppy control circuit (`ctrl_circ`). It synchronises the asynchronous active-low bus inputs and rejects runt or deselected STEP pulses. Accepted steps and their directions are queued and replayed to the control circuit as clean single-cycle `step` pulses with `dir_sel`, paced by the stepper's busy indication.

---
 rtl/floppy_pkg.sv | 23 ++
 rtl/step_dir_fifo.sv | 68 ++++++
 rtl/shugart_step_rx.sv | 197 +++++++++++++++++++
 tb/tb_shugart_step_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/floppy_pkg.sv
// rtl/floppy_pkg.sv - shared constants and state types for the Shugart STEP/DIR receiver
package floppy_pkg;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int MIN_PULSE_CYC_DEF = 50;
  localparam int ISSUE_GAP_CYC_DEF = 4;
  localparam int DEPTH_DEF         = 4;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_LOW  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    I_IDLE  = 2'd0,
    I_SETUP = 2'd1,
    I_PULSE = 2'd2,
    I_HOLD  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/step_dir_fifo.sv
// rtl/step_dir_fifo.sv - 1-bit wide FIFO holding the direction of each queued step
module step_dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shugart_step_rx.sv
// rtl/shugart_step_rx.sv - STEP/DIR receiver: synchronise, qualify, queue and replay head steps
module shugart_step_rx
  import floppy_pkg::*;
#(
  parameter int MIN_PULSE_CYC = MIN_PULSE_CYC_DEF,
  parameter int ISSUE_GAP_CYC = ISSUE_GAP_CYC_DEF,
  parameter int DEPTH         = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_n,
  input  logic                   dir_n,
  input  logic                   sel_n,
  input  logic                   step_busy,
  input  logic                   clr_ovf,
  output logic                   step,
  output logic                   dir_sel,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic                   glitch
);

  localparam int CW = $clog2(MIN_PULSE_CYC + 1);
  localparam int HW = $clog2(ISSUE_GAP_CYC + 1);
  localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_PULSE_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ISSUE_GAP_CYC - 1);

  logic [1:0] step_s_q, step_s_d;
  logic [1:0] dir_s_q, dir_s_d;
  logic [1:0] sel_s_q, sel_s_d;
  logic       step_prev_q, step_prev_d;

  rx_state_t    rx_state_q, rx_state_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic          abort_q, abort_d;
  logic          dir_cap_q, dir_cap_d;
  logic          glitch_q, glitch_d;
  logic          overflow_q, overflow_d;

  issue_state_t  issue_q, issue_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          dir_sel_q, dir_sel_d;
  logic          step_q, step_d;

  logic step_sync, step_fall, step_rise, selected;
  logic accept, pop, fifo_push;
  logic fifo_head, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign step_s_d    = {step_s_q[0], step_n};
  assign dir_s_d     = {dir_s_q[0], dir_n};
  assign sel_s_d     = {sel_s_q[0], sel_n};
  assign step_prev_d = step_s_q[1];

  assign step_sync = step_s_q[1];
  assign step_fall = step_prev_q & ~step_sync;
  assign step_rise = ~step_prev_q & step_sync;
  assign selected  = ~sel_s_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    low_cnt_d  = low_cnt_q;
    abort_d    = abort_q;
    dir_cap_d  = dir_cap_q;
    accept     = 1'b0;
    glitch_d   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (step_fall && selected) begin
          rx_state_d = R_LOW;
          low_cnt_d  = '0;
          abort_d    = 1'b0;
          dir_cap_d  = dir_s_q[1] ? DIR_OUT : DIR_IN;
        end
      end
      R_LOW: begin
        if (low_cnt_q != MIN_CNT) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
        if (!selected) begin
          abort_d = 1'b1;
        end
        if (step_rise) begin
          rx_state_d = R_IDLE;
          if (low_cnt_q == MIN_CNT && !abort_q && selected) begin
            accept = 1'b1;
          end else begin
            glitch_d = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // An accept that finds the queue still full after this cycle's pop is dropped.
  assign fifo_push = accept & (~fifo_full | pop);

  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (accept && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    issue_d   = issue_q;
    hold_d    = hold_q;
    dir_sel_d = dir_sel_q;
    step_d    = 1'b0;
    pop       = 1'b0;
    case (issue_q)
      I_IDLE: begin
        if (fifo_count != '0 && !step_busy) begin
          issue_d   = I_SETUP;
          dir_sel_d = fifo_head;
        end
      end
      I_SETUP: begin
        issue_d = I_PULSE;
        step_d  = 1'b1;
      end
      I_PULSE: begin
        issue_d = I_HOLD;
        pop     = 1'b1;
        hold_d  = '0;
      end
      I_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          issue_d = I_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: issue_d = I_IDLE;
    endcase
  end

  step_dir_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (dir_cap_q),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // STEP synchroniser resets low so a pulse already in flight at reset release is never seen falling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s_q    <= 2'b00;
      dir_s_q     <= 2'b00;
      sel_s_q     <= 2'b11;
      step_prev_q <= 1'b0;
      rx_state_q  <= R_IDLE;
      low_cnt_q   <= '0;
      abort_q     <= 1'b0;
      dir_cap_q   <= DIR_IN;
      glitch_q    <= 1'b0;
      overflow_q  <= 1'b0;
      issue_q     <= I_IDLE;
      hold_q      <= '0;
      dir_sel_q   <= DIR_IN;
      step_q      <= 1'b0;
    end else begin
      step_s_q    <= step_s_d;
      dir_s_q     <= dir_s_d;
      sel_s_q     <= sel_s_d;
      step_prev_q <= step_prev_d;
      rx_state_q  <= rx_state_d;
      low_cnt_q   <= low_cnt_d;
      abort_q     <= abort_d;
      dir_cap_q   <= dir_cap_d;
      glitch_q    <= glitch_d;
      overflow_q  <= overflow_d;
      issue_q     <= issue_d;
      hold_q      <= hold_d;
      dir_sel_q   <= dir_sel_d;
      step_q      <= step_d;
    end
  end

  assign step     = step_q;
  assign dir_sel  = dir_sel_q;
  assign pending  = fifo_count;
  assign overflow = overflow_q;
  assign glitch   = glitch_q;

endmodule

// File: tb/tb_shugart_step_rx.sv
// tb/tb_shugart_step_rx.sv - scoreboard bench for shugart_step_rx
module tb_shugart_step_rx;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_n, dir_n, sel_n, step_busy, clr_ovf;
  logic          step, dir_sel, overflow, glitch;
  logic [PW-1:0] pending;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  int   step_cnt = 0;
  int   glitch_cnt = 0;
  int   cyc = 0;
  int   last_step_cyc = -100;
  logic prev_dir_sel = 1'b0;

  always #5 clk = ~clk;

  shugart_step_rx #(
    .MIN_PULSE_CYC(50),
    .ISSUE_GAP_CYC(4),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_n    (step_n),
    .dir_n     (dir_n),
    .sel_n     (sel_n),
    .step_busy (step_busy),
    .clr_ovf   (clr_ovf),
    .step      (step),
    .dir_sel   (dir_sel),
    .pending   (pending),
    .overflow  (overflow),
    .glitch    (glitch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_dir_sel"}, dir_sel, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_glitch"}, glitch, 0);
  endtask

  task automatic send_step(input int low, input logic d, input int drop_at,
                           input logic sel_on, input logic exp_issue, input logic clr_at_accept);
    dir_n = d;
    sel_n = ~sel_on;
    repeat (3) @(negedge clk);
    if (exp_issue) exp_q.push_back(d);
    step_n = 1'b0;
    for (int i = 0; i < low; i++) begin
      if (drop_at != 0 && i == drop_at) sel_n = 1'b1;
      @(negedge clk);
    end
    step_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      clr_ovf = clr_at_accept && (i == 3);
      @(negedge clk);
    end
    clr_ovf = 1'b0;
    sel_n   = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (glitch) glitch_cnt++;
      if (step) begin
        step_cnt++;
        chk("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("step_dir", dir_sel, exp_q.pop_front());
        chk("dir_setup", prev_dir_sel, dir_sel);
        chk("spacing_ok", (cyc - last_step_cyc) >= 6, 1);
        last_step_cyc = cyc;
      end
    end
    prev_dir_sel = dir_sel;
  end

  initial begin
    int s0, g0, lat;
    logic seen;
    rst = 1'b0; step_n = 1'b1; dir_n = 1'b0; sel_n = 1'b1; step_busy = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst");
    rst = 1'b1;
    sel_n = 1'b0;
    repeat (5) @(negedge clk);

    // Single valid step: latency and direction.
    dir_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(1'b1);
    s0 = step_cnt;
    step_n = 1'b0;
    repeat (60) @(negedge clk);
    step_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) chk("pending_at_accept", pending, 1);
      if (step && lat == 0) lat = k;
    end
    chk("step_latency", lat, 5);
    repeat (10) @(negedge clk);
    chk("t1_steps", step_cnt - s0, 1);
    chk("t1_pending", pending, 0);
    chk("t1_glitch", glitch_cnt, 0);

    // Runt pulse.
    g0 = glitch_cnt; s0 = step_cnt;
    send_step(30, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("runt_glitch", glitch_cnt - g0, 1);
    chk("runt_steps", step_cnt - s0, 0);
    chk("runt_pending", pending, 0);

    // Select dropped mid-pulse.
    g0 = glitch_cnt; s0 = step_cnt;
    send_step(60, 1'b0, 30, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("desel_glitch", glitch_cnt - g0, 1);
    chk("desel_steps", step_cnt - s0, 0);

    // Never selected.
    g0 = glitch_cnt; s0 = step_cnt;
    send_step(60, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("nosel_glitch", glitch_cnt - g0, 0);
    chk("nosel_steps", step_cnt - s0, 0);

    // Busy held: fill, overflow, set-wins-over-clear.
    step_busy = 1'b1;
    s0 = step_cnt;
    for (int i = 0; i < 6; i++) begin
      send_step(60, 1'(i % 2), 0, 1'b1, i < 4, i == 5);
    end
    chk("full_pending", pending, 4);
    chk("ovf_set_wins", overflow, 1);
    chk("busy_no_steps", step_cnt - s0, 0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("pending_after_clr", pending, 4);
    step_busy = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (step_cnt - s0 >= 4) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("drain_steps", step_cnt - s0, 4);
    chk("drain_pending", pending, 0);
    chk("drain_sb_empty", exp_q.size(), 0);

    // Reset while holding with two steps still queued.
    step_busy = 1'b1;
    send_step(60, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    send_step(60, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send_step(60, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_pending", pending, 3);
    step_busy = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_step_seen", seen, 1);
    @(negedge clk);
    chk("hold_pending", pending, 2);
    rst = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s0 = step_cnt;
    repeat (40) @(negedge clk);
    chk("post_rst_steps", step_cnt - s0, 0);
    chk("post_rst_pending", pending, 0);
    send_step(60, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("post_rst_new_step", step_cnt - s0, 1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
